test_sequencer: RTL and testbench

Synthesizable run controller for the processor test suite. It sits directly upstream of the individual component and instruction test modules. It launches each test in turn with a start pulse, waits for that test's done/pass handshake, and enforces a per-test cycle timeout. It tallies pass, fail and timeout counts into a summary that the top-level bench reports.

---
 rtl/test_seq_pkg.sv | 24 ++
 rtl/seq_watchdog.sv | 29 ++
 rtl/test_sequencer.sv | 140 ++++++++++++++
 tb/tb_test_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/test_seq_pkg.sv
// Shared types and width helpers for the test-suite run controller.
// Holds the sequencer state encoding and the default per-test timeout.
package test_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RECORD,
    DONE
  } seq_state_e;

  localparam int unsigned DEFAULT_TIMEOUT = 1024;

  // Index width never collapses to zero, even for a single slot.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Per-test cycle watchdog: counts enabled cycles, flags expiry at TIMEOUT-1.
// Registered count, expiry is a compare on it; saturates, clear has priority.
module seq_watchdog
  import test_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned WW = $clog2(TIMEOUT);

  logic [WW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + WW'(1);
    end
  end

  assign o_expired = (r_count == WW'(TIMEOUT - 1));

endmodule

// File: rtl/test_sequencer.sv
// Launches each test slot in turn, waits for done or watchdog expiry, tallies verdicts.
// Outputs derive only from registers; optional SEQ_STOP_ON_FAIL_EN ends the run on the first fail.
module test_sequencer
  import test_seq_pkg::*;
#(
  parameter int unsigned NUM_TESTS = 8,
  parameter int unsigned TIMEOUT   = DEFAULT_TIMEOUT,
  localparam int unsigned IW = idx_width(NUM_TESTS),
  localparam int unsigned CW = cnt_width(NUM_TESTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_TESTS-1:0] test_done,
  input  logic [NUM_TESTS-1:0] test_pass,
  output logic [NUM_TESTS-1:0] test_start,
  output logic [IW-1:0]        current_test,
  output logic                 busy,
  output logic                 finished,
  output logic [CW-1:0]        pass_count,
  output logic [CW-1:0]        fail_count,
  output logic [CW-1:0]        timeout_count,
  output logic [NUM_TESTS-1:0] result_mask,
  output logic                 all_passed
);

  seq_state_e           r_state;
  seq_state_e           w_next;
  logic [IW-1:0]        r_cur;
  logic [CW-1:0]        r_pass_cnt;
  logic [CW-1:0]        r_fail_cnt;
  logic [CW-1:0]        r_tmo_cnt;
  logic [NUM_TESTS-1:0] r_mask;
  logic                 r_pass;
  logic                 r_tmo;
  logic                 w_done;
  logic                 w_expired;
  logic                 w_wd_clear;
  logic                 w_stop;
  logic                 w_run_start;

  assign w_done      = test_done[r_cur];
  assign w_run_start = ((r_state == IDLE) || (r_state == DONE)) && start;
  assign w_wd_clear  = w_run_start || (r_state == LAUNCH);

`ifdef SEQ_STOP_ON_FAIL_EN
  assign w_stop = !r_pass;
`else
  assign w_stop = 1'b0;
`endif

  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_wd_clear),
    .i_enable  (r_state == WAIT),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_next = LAUNCH;
      LAUNCH:     w_next = WAIT;
      WAIT:       if (w_done || w_expired) w_next = RECORD;
      RECORD: begin
        if ((r_cur == IW'(NUM_TESTS - 1)) || w_stop) w_next = DONE;
        else                                         w_next = LAUNCH;
      end
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur      <= '0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_tmo_cnt  <= '0;
      r_mask     <= '0;
      r_pass     <= 1'b0;
      r_tmo      <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_cur      <= '0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_tmo_cnt  <= '0;
            r_mask     <= '0;
          end
        end
        WAIT: begin
          // Done outranks a same-cycle expiry; an unknown verdict falls to fail.
          if (w_done) begin
            if (test_pass[r_cur]) r_pass <= 1'b1;
            else                  r_pass <= 1'b0;
            r_tmo <= 1'b0;
          end else if (w_expired) begin
            r_pass <= 1'b0;
            r_tmo  <= 1'b1;
          end
        end
        RECORD: begin
          if (r_pass) begin
            r_pass_cnt    <= r_pass_cnt + CW'(1);
            r_mask[r_cur] <= 1'b1;
          end else begin
            r_fail_cnt <= r_fail_cnt + CW'(1);
            if (r_tmo) r_tmo_cnt <= r_tmo_cnt + CW'(1);
          end
          if (w_next == LAUNCH) r_cur <= r_cur + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign test_start    = (r_state == LAUNCH) ? (NUM_TESTS'(1) << r_cur) : '0;
  assign current_test  = r_cur;
  assign busy          = (r_state == LAUNCH) || (r_state == WAIT) || (r_state == RECORD);
  assign finished      = (r_state == DONE);
  assign pass_count    = r_pass_cnt;
  assign fail_count    = r_fail_cnt;
  assign timeout_count = r_tmo_cnt;
  assign result_mask   = r_mask;
  assign all_passed    = finished && (r_fail_cnt == '0);

endmodule

// File: tb/tb_test_sequencer.sv
// Randomized bench for test_sequencer: stub test slots plus a per-run timing/tally model.
// Expected launch cycles, finish cycle and tallies come from per-slot durations.
module tb_test_sequencer;

  localparam int NT  = 4;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [NT-1:0] test_done;
  logic [NT-1:0] test_pass;
  logic [NT-1:0] test_start;
  logic [1:0]    current_test;
  logic          busy;
  logic          finished;
  logic [2:0]    pass_count;
  logic [2:0]    fail_count;
  logic [2:0]    timeout_count;
  logic [NT-1:0] result_mask;
  logic          all_passed;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Stub behaviour per slot: delay 0 means the slot never signals done.
  int slot_delay [NT];
  bit slot_pass  [NT];
  int launch_cyc [NT];
  bit launched   [NT];
  int lq_cyc[$];
  logic [NT-1:0] lq_vec[$];

  test_sequencer #(
    .NUM_TESTS (NT),
    .TIMEOUT   (TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .test_done     (test_done),
    .test_pass     (test_pass),
    .test_start    (test_start),
    .current_test  (current_test),
    .busy          (busy),
    .finished      (finished),
    .pass_count    (pass_count),
    .fail_count    (fail_count),
    .timeout_count (timeout_count),
    .result_mask   (result_mask),
    .all_passed    (all_passed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < NT; i++) begin
      if (test_start[i]) begin
        launch_cyc[i] = cyc;
        launched[i]   = 1'b1;
      end
    end
    if (test_start != '0) begin
      lq_cyc.push_back(cyc);
      lq_vec.push_back(test_start);
    end
  end

  // Verdict line carries the inverse value until done, so early latching shows up.
  always_comb begin
    test_done = '0;
    test_pass = '0;
    for (int i = 0; i < NT; i++) begin
      if (launched[i] && slot_delay[i] != 0 && (cyc - launch_cyc[i]) >= slot_delay[i])
        test_done[i] = 1'b1;
      test_pass[i] = test_done[i] ? slot_pass[i] : ~slot_pass[i];
    end
  end

  task automatic run_and_check(input string name, input bit poke_start);
    int c0, base, t, dur, got_fin, n, exp_fin;
    int ep, ef, et, last;
    bit ok, to, stop;
    int exp_cyc[$];
    logic [NT-1:0] exp_vec[$];
    logic [NT-1:0] em;
    ep = 0; ef = 0; et = 0; em = '0; stop = 1'b0; last = 0;
    @(negedge clk);
    start = 1'b1;
    c0 = cyc;
    base = lq_cyc.size();
    t = c0 + 1;
    for (int i = 0; i < NT; i++) begin
      if (!stop) begin
        exp_cyc.push_back(t);
        exp_vec.push_back(NT'(1) << i);
        last = i;
        ok = (slot_delay[i] != 0) && (slot_delay[i] <= TMO);
        to = !ok;
        dur = ok ? slot_delay[i] + 2 : TMO + 2;
        ok = ok && slot_pass[i];
        t += dur;
        if (ok) begin
          ep++;
          em[i] = 1'b1;
        end else begin
          ef++;
          if (to) et++;
`ifdef SEQ_STOP_ON_FAIL_EN
          stop = 1'b1;
`endif
        end
      end
    end
    exp_fin = t;
    got_fin = -1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      start = poke_start && (cyc == c0 + 4);
      if (finished) begin
        got_fin = cyc;
        break;
      end
    end
    start = 1'b0;
    vectors++;
    if (got_fin !== exp_fin) begin
      miscompares++;
      $display("FAIL %s finish_cycle got %0d want %0d", name, got_fin, exp_fin);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (finished !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s done_hold finished=%b busy=%b want 1/0", name, finished, busy);
    end
    vectors++;
    if (pass_count !== 3'(ep)) begin
      miscompares++;
      $display("FAIL %s pass_count got %0d want %0d", name, pass_count, ep);
    end
    vectors++;
    if (fail_count !== 3'(ef)) begin
      miscompares++;
      $display("FAIL %s fail_count got %0d want %0d", name, fail_count, ef);
    end
    vectors++;
    if (timeout_count !== 3'(et)) begin
      miscompares++;
      $display("FAIL %s timeout_count got %0d want %0d", name, timeout_count, et);
    end
    vectors++;
    if (result_mask !== em) begin
      miscompares++;
      $display("FAIL %s result_mask got %b want %b", name, result_mask, em);
    end
    vectors++;
    if (all_passed !== (ef == 0)) begin
      miscompares++;
      $display("FAIL %s all_passed got %b want %b", name, all_passed, ef == 0);
    end
    vectors++;
    if (current_test !== 2'(last)) begin
      miscompares++;
      $display("FAIL %s current_test got %0d want %0d", name, current_test, last);
    end
    n = lq_cyc.size() - base;
    vectors++;
    if (n != exp_cyc.size()) begin
      miscompares++;
      $display("FAIL %s launch_count got %0d want %0d", name, n, exp_cyc.size());
    end
    for (int j = 0; j < n && j < exp_cyc.size(); j++) begin
      vectors++;
      if (lq_cyc[base+j] != exp_cyc[j] || lq_vec[base+j] !== exp_vec[j]) begin
        miscompares++;
        $display("FAIL %s launch%0d got cyc %0d vec %b want cyc %0d vec %b",
                 name, j, lq_cyc[base+j] - c0, lq_vec[base+j], exp_cyc[j] - c0, exp_vec[j]);
      end
    end
  endtask

  task automatic set_slots(input int d0, d1, d2, d3, input bit p0, p1, p2, p3);
    slot_delay[0] = d0; slot_delay[1] = d1; slot_delay[2] = d2; slot_delay[3] = d3;
    slot_pass[0]  = p0; slot_pass[1]  = p1; slot_pass[2]  = p2; slot_pass[3]  = p3;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (test_start !== '0 || current_test !== '0 || busy !== 1'b0 || finished !== 1'b0) begin
      miscompares++;
      $display("FAIL reset ctrl start=%b cur=%0d busy=%b fin=%b want 0", test_start, current_test, busy, finished);
    end
    vectors++;
    if (pass_count !== '0 || fail_count !== '0 || timeout_count !== '0 || result_mask !== '0 || all_passed !== 1'b0) begin
      miscompares++;
      $display("FAIL reset tallies p=%0d f=%0d t=%0d m=%b ap=%b want 0", pass_count, fail_count, timeout_count, result_mask, all_passed);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_pass();
    set_slots(3, 3, 3, 3, 1, 1, 1, 1);
    run_and_check("all_pass", 1'b0);
  endtask

  task automatic test_slot_fail();
    set_slots(3, 3, 3, 3, 1, 1, 0, 1);
    run_and_check("slot2_fail", 1'b0);
  endtask

  task automatic test_timeout();
    set_slots(2, 0, 4, 1, 1, 1, 1, 1);
    run_and_check("slot1_timeout", 1'b0);
  endtask

  task automatic test_expiry_tie();
    set_slots(TMO, 2, 2, 2, 1, 1, 1, 1);
    run_and_check("expiry_tie", 1'b0);
  endtask

  task automatic test_start_while_busy();
    set_slots(5, 2, 3, 1, 1, 0, 1, 1);
    run_and_check("start_busy", 1'b1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NT; i++) begin
        slot_delay[i] = $urandom_range(0, 20);
        slot_pass[i]  = 1'($urandom_range(0, 1));
      end
      run_and_check($sformatf("random%0d", r), 1'b0);
    end
  endtask

  task automatic test_mid_reset();
    int base, snap;
    bit seen;
    set_slots(2, 2, 0, 2, 1, 1, 1, 1);
    @(negedge clk);
    start = 1'b1;
    base = lq_cyc.size();
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      seen = (lq_cyc.size() >= base + 3);
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL mid_reset slot2_launch got none want launch within 200 cycles");
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (busy !== 1'b0 || finished !== 1'b0 || test_start !== '0 || current_test !== '0) begin
      miscompares++;
      $display("FAIL mid_reset ctrl busy=%b fin=%b start=%b cur=%0d want 0", busy, finished, test_start, current_test);
    end
    vectors++;
    if (pass_count !== '0 || fail_count !== '0 || timeout_count !== '0 || result_mask !== '0) begin
      miscompares++;
      $display("FAIL mid_reset tallies p=%0d f=%0d t=%0d m=%b want 0", pass_count, fail_count, timeout_count, result_mask);
    end
    snap = lq_cyc.size();
    repeat (20) @(negedge clk);
    vectors++;
    if (lq_cyc.size() != snap || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset idle_hold launches got %0d busy=%b want 0/0", lq_cyc.size() - snap, busy);
    end
    set_slots(1, 1, 1, 1, 1, 1, 1, 1);
    run_and_check("after_reset", 1'b0);
  endtask

  initial begin
    for (int i = 0; i < NT; i++) begin
      slot_delay[i] = 1;
      slot_pass[i]  = 1'b1;
    end
    test_reset();
    test_all_pass();
    test_slot_fail();
    test_timeout();
    test_expiry_tie();
    test_start_while_busy();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
